// File: rtl/falafel_mp_frontend_if.sv
// rtl/falafel_mp_frontend_if.sv - client and core handshake bundle for falafel_mp_frontend
// master = clients/core side, slave = front end.
interface falafel_mp_frontend_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS-1:0]        cli_req_val_i;
  logic [NUM_PORTS-1:0]        cli_req_rdy_o;
  logic [NUM_PORTS-1:0]        cli_req_is_free_i;
  logic [NUM_PORTS*DATA_W-1:0] cli_req_data_i;
  logic [NUM_PORTS-1:0]        cli_resp_val_o;
  logic [NUM_PORTS-1:0]        cli_resp_rdy_i;
  logic [NUM_PORTS*DATA_W-1:0] cli_resp_data_o;
  logic                        core_req_val_o;
  logic                        core_req_rdy_i;
  logic                        core_req_is_free_o;
  logic [DATA_W-1:0]           core_req_data_o;
  logic                        core_resp_val_i;
  logic                        core_resp_rdy_o;
  logic [DATA_W-1:0]           core_resp_data_i;
  logic [31:0]                 stat_alloc_cnt_o;
  logic [31:0]                 stat_free_cnt_o;

  modport master (
    output cli_req_val_i, cli_req_is_free_i, cli_req_data_i, cli_resp_rdy_i,
           core_req_rdy_i, core_resp_val_i, core_resp_data_i,
    input  cli_req_rdy_o, cli_resp_val_o, cli_resp_data_o, core_req_val_o,
           core_req_is_free_o, core_req_data_o, core_resp_rdy_o,
           stat_alloc_cnt_o, stat_free_cnt_o
  );

  modport slave (
    input  cli_req_val_i, cli_req_is_free_i, cli_req_data_i, cli_resp_rdy_i,
           core_req_rdy_i, core_resp_val_i, core_resp_data_i,
    output cli_req_rdy_o, cli_resp_val_o, cli_resp_data_o, core_req_val_o,
           core_req_is_free_o, core_req_data_o, core_resp_rdy_o,
           stat_alloc_cnt_o, stat_free_cnt_o
  );
endinterface

// File: rtl/falafel_mp_frontend.sv
// rtl/falafel_mp_frontend.sv - per-client request FIFOs, round-robin merge to falafel_core, in-order response steering
// Optional issue counters are built only with FALAFEL_FE_STATS_EN defined.
module falafel_mp_frontend #(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_W          = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  falafel_mp_frontend_if.slave bus
);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_PORTS-1:0][FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic [NUM_PORTS-1:0][FIFO_DEPTH-1:0]             fifo_free_q, fifo_free_d;
  logic [NUM_PORTS-1:0][AW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [NUM_PORTS-1:0][AW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [NUM_PORTS-1:0][CW-1:0]                     cnt_q, cnt_d;
  logic [PW-1:0]                                    rr_ptr_q, rr_ptr_d;
  logic                                             core_req_val_q, core_req_val_d;
  logic                                             core_req_is_free_q, core_req_is_free_d;
  logic [DATA_W-1:0]                                core_req_data_q, core_req_data_d;
  logic [MAX_OUTSTANDING-1:0][PW-1:0]               tag_mem_q, tag_mem_d;
  logic [TW-1:0]                                    tag_wr_q, tag_wr_d;
  logic [TW-1:0]                                    tag_rd_q, tag_rd_d;
  logic [TCW-1:0]                                   tag_cnt_q, tag_cnt_d;
  logic [NUM_PORTS-1:0]                             resp_val_q, resp_val_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]                 resp_data_q, resp_data_d;

  logic [NUM_PORTS-1:0]             head_free;
  logic [NUM_PORTS-1:0][DATA_W-1:0] head_data;
  logic [NUM_PORTS-1:0]             elig;
  logic [NUM_PORTS-1:0]             push;
  logic [NUM_PORTS-1:0]             pop;
  logic [PW-1:0]                    grant;
  logic                             grant_vld;
  logic                             load;
  logic                             tag_room;
  logic                             tag_push;
  logic                             tag_pop;
  logic [PW-1:0]                    head_tag;
  logic                             core_resp_rdy;

  // The tag check uses registered occupancy only, so a response popping a tag
  // this cycle does not unblock an alloc until the next one.
  always_comb begin
    tag_room  = (tag_cnt_q != TCW'(MAX_OUTSTANDING));
    head_free = '0;
    head_data = '0;
    elig      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      head_free[p] = fifo_free_q[p][rd_ptr_q[p]];
      head_data[p] = fifo_data_q[p][rd_ptr_q[p]];
      elig[p]      = (cnt_q[p] != '0) && (head_free[p] || tag_room);
    end
  end

  always_comb begin
    int          idx_i;
    logic [PW-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx_i     = 0;
    idx       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx_i = (int'(rr_ptr_q) + i) % NUM_PORTS;
      idx   = PW'(idx_i);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign load     = grant_vld && (!core_req_val_q || bus.core_req_rdy_i);
  assign tag_push = load && !head_free[grant];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      rr_ptr_d = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_free_d = fifo_free_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    push        = '0;
    pop         = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p] = bus.cli_req_val_i[p] && (cnt_q[p] != CW'(FIFO_DEPTH));
      pop[p]  = load && (grant == PW'(p));
      if (push[p]) begin
        fifo_data_d[p][wr_ptr_q[p]] = bus.cli_req_data_i[p*DATA_W +: DATA_W];
        fifo_free_d[p][wr_ptr_q[p]] = bus.cli_req_is_free_i[p];
        wr_ptr_d[p]                 = wr_ptr_q[p] + 1'b1;
      end
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      end
      cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
    end
  end

  always_comb begin
    core_req_val_d     = core_req_val_q;
    core_req_is_free_d = core_req_is_free_q;
    core_req_data_d    = core_req_data_q;
    if (!core_req_val_q || bus.core_req_rdy_i) begin
      core_req_val_d = grant_vld;
      if (grant_vld) begin
        core_req_is_free_d = head_free[grant];
        core_req_data_d    = head_data[grant];
      end
    end
  end

  // Responses return in issue order, so the oldest tag names the target slot.
  always_comb begin
    head_tag      = tag_mem_q[tag_rd_q];
    core_resp_rdy = (tag_cnt_q != '0) &&
                    (!resp_val_q[head_tag] || bus.cli_resp_rdy_i[head_tag]);
    tag_pop       = bus.core_resp_val_i && core_resp_rdy;
    tag_mem_d     = tag_mem_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    if (tag_push) begin
      tag_mem_d[tag_wr_q] = grant;
      tag_wr_d = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
    end
    if (tag_pop) begin
      tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
    end
    tag_cnt_d = tag_cnt_q + TCW'(tag_push) - TCW'(tag_pop);
  end

  always_comb begin
    resp_val_d  = resp_val_q;
    resp_data_d = resp_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (resp_val_q[p] && bus.cli_resp_rdy_i[p]) begin
        resp_val_d[p] = 1'b0;
      end
    end
    if (tag_pop) begin
      resp_val_d[head_tag]  = 1'b1;
      resp_data_d[head_tag] = bus.core_resp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      cnt_q              <= '0;
      rr_ptr_q           <= '0;
      core_req_val_q     <= 1'b0;
      core_req_is_free_q <= 1'b0;
      core_req_data_q    <= '0;
      tag_wr_q           <= '0;
      tag_rd_q           <= '0;
      tag_cnt_q          <= '0;
      resp_val_q         <= '0;
      resp_data_q        <= '0;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      cnt_q              <= cnt_d;
      rr_ptr_q           <= rr_ptr_d;
      core_req_val_q     <= core_req_val_d;
      core_req_is_free_q <= core_req_is_free_d;
      core_req_data_q    <= core_req_data_d;
      tag_wr_q           <= tag_wr_d;
      tag_rd_q           <= tag_rd_d;
      tag_cnt_q          <= tag_cnt_d;
      resp_val_q         <= resp_val_d;
      resp_data_q        <= resp_data_d;
    end
  end

  // Storage arrays are gated by the pointers/counts and need no reset.
  always_ff @(posedge clk_i) begin
    fifo_data_q <= fifo_data_d;
    fifo_free_q <= fifo_free_d;
    tag_mem_q   <= tag_mem_d;
  end

  always_comb begin
    bus.cli_req_rdy_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.cli_req_rdy_o[p] = (cnt_q[p] != CW'(FIFO_DEPTH));
    end
  end

  assign bus.cli_resp_val_o     = resp_val_q;
  assign bus.cli_resp_data_o    = resp_data_q;
  assign bus.core_req_val_o     = core_req_val_q;
  assign bus.core_req_is_free_o = core_req_is_free_q;
  assign bus.core_req_data_o    = core_req_data_q;
  assign bus.core_resp_rdy_o    = core_resp_rdy;

`ifdef FALAFEL_FE_STATS_EN
  logic [31:0] stat_alloc_q, stat_alloc_d;
  logic [31:0] stat_free_q, stat_free_d;

  always_comb begin
    stat_alloc_d = stat_alloc_q;
    stat_free_d  = stat_free_q;
    if (core_req_val_q && bus.core_req_rdy_i) begin
      if (core_req_is_free_q) begin
        if (stat_free_q != '1) stat_free_d = stat_free_q + 1'b1;
      end else begin
        if (stat_alloc_q != '1) stat_alloc_d = stat_alloc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_alloc_q <= '0;
      stat_free_q  <= '0;
    end else begin
      stat_alloc_q <= stat_alloc_d;
      stat_free_q  <= stat_free_d;
    end
  end

  assign bus.stat_alloc_cnt_o = stat_alloc_q;
  assign bus.stat_free_cnt_o  = stat_free_q;
`else
  assign bus.stat_alloc_cnt_o = '0;
  assign bus.stat_free_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_falafel_mp_frontend.sv
// tb/tb_falafel_mp_frontend.sv - directed scenarios plus randomized scoreboard for falafel_mp_frontend
module tb_falafel_mp_frontend;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int FD = 4;
  localparam int MO = 8;

  typedef struct {
    logic        f;
    logic [63:0] d;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  falafel_mp_frontend_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  falafel_mp_frontend #(
    .NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.cli_req_val_i     = '0;
    bus.cli_req_is_free_i = '0;
    bus.cli_req_data_i    = '0;
    bus.cli_resp_rdy_i    = '0;
    bus.core_req_rdy_i    = 1'b0;
    bus.core_resp_val_i   = 1'b0;
    bus.core_resp_data_i  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic req(input int p, input logic f, input logic [63:0] d);
    bus.cli_req_val_i[p]          = 1'b1;
    bus.cli_req_is_free_i[p]      = f;
    bus.cli_req_data_i[p*DW +: DW] = d;
  endtask

  function automatic logic [63:0] rdata(input int p);
    return bus.cli_resp_data_o[p*DW +: DW];
  endfunction

  req_t        exp_q [NP][$];
  int          tagq[$];
  int          order[$];
  logic        slot_full [NP];
  logic [63:0] slot_d [NP];
  int          seqn [NP];
  int          n_alloc;
  int          n_free;
  int          acc;

  initial begin
    idle();
    tick();
    tick();
    // ---- reset state
    chk("rst_core_val", bus.core_req_val_o, 0);
    chk("rst_core_data", bus.core_req_data_o, 0);
    chk("rst_resp_val", bus.cli_resp_val_o, 0);
    chk("rst_req_rdy", bus.cli_req_rdy_o, 4'hF);
    chk("rst_core_resp_rdy", bus.core_resp_rdy_o, 0);
    chk("rst_stat_alloc", bus.stat_alloc_cnt_o, 0);
    chk("rst_stat_free", bus.stat_free_cnt_o, 0);
    rst = 1'b0;

    // ---- single alloc from port 2
    req(2, 1'b0, 64'h40);
    settle();
    chk("single_req_rdy", bus.cli_req_rdy_o[2], 1);
    tick();
    bus.cli_req_val_i = '0;
    chk("single_val_early", bus.core_req_val_o, 0);
    tick();
    chk("single_val", bus.core_req_val_o, 1);
    chk("single_data", bus.core_req_data_o, 64'h40);
    chk("single_is_free", bus.core_req_is_free_o, 0);
    bus.core_req_rdy_i = 1'b1;
    tick();
    bus.core_req_rdy_i = 1'b0;
    chk("single_val_drop", bus.core_req_val_o, 0);
    bus.core_resp_val_i  = 1'b1;
    bus.core_resp_data_i = 64'h1000;
    settle();
    chk("single_core_resp_rdy", bus.core_resp_rdy_o, 1);
    tick();
    bus.core_resp_val_i = 1'b0;
    chk("single_resp_val", bus.cli_resp_val_o, 4'b0100);
    chk("single_resp_data", rdata(2), 64'h1000);
    bus.cli_resp_rdy_i[2] = 1'b1;
    tick();
    chk("single_resp_drain", bus.cli_resp_val_o, 0);

    // ---- fairness and tag-full blocking
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < NP; p++) req(p, 1'b0, 64'(p) | (64'(c) << 8));
      tick();
    end
    bus.cli_req_val_i  = '0;
    bus.core_req_rdy_i = 1'b1;
    order.delete();
    for (int c = 0; c < 20; c++) begin
      if (bus.core_req_val_o) order.push_back(int'(bus.core_req_data_o[7:0]));
      tick();
    end
    bus.core_req_rdy_i = 1'b0;
    chk("fair_count", 64'(order.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < order.size()) chk($sformatf("fair_grant%0d", i), 64'(order[i]), 64'(i % 4));
    end
    chk("fair_blocked_val", bus.core_req_val_o, 0);
    bus.cli_resp_rdy_i   = '1;
    bus.core_resp_val_i  = 1'b1;
    bus.core_resp_data_i = 64'h55;
    settle();
    chk("fair_resp_rdy", bus.core_resp_rdy_o, 1);
    tick();
    bus.core_resp_val_i = 1'b0;
    tick();
    chk("fair_unblock_val", bus.core_req_val_o, 1);
    chk("fair_unblock_port", bus.core_req_data_o[7:0], 0);

    // ---- free bypasses a tag-blocked alloc
    do_reset();
    bus.core_req_rdy_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req(0, 1'b0, 64'(c));
      tick();
    end
    bus.cli_req_val_i = '0;
    repeat (4) tick();
    chk("bypass_tags_full", bus.core_req_val_o, 0);
    bus.core_req_rdy_i = 1'b0;
    req(1, 1'b0, 64'h111);
    req(3, 1'b1, 64'h2000);
    tick();
    bus.cli_req_val_i = '0;
    tick();
    chk("bypass_val", bus.core_req_val_o, 1);
    chk("bypass_is_free", bus.core_req_is_free_o, 1);
    chk("bypass_data", bus.core_req_data_o, 64'h2000);
    bus.core_req_rdy_i = 1'b1;
    tick();
    tick();
    chk("bypass_alloc_waits", bus.core_req_val_o, 0);

    // ---- in-order routing with a stalled client
    do_reset();
    bus.core_req_rdy_i = 1'b1;
    bus.cli_resp_rdy_i = 4'b0111;
    req(3, 1'b0, 64'h3);
    tick();
    bus.cli_req_val_i = '0;
    req(0, 1'b0, 64'h0);
    tick();
    bus.cli_req_val_i = '0;
    req(3, 1'b0, 64'h3);
    tick();
    bus.cli_req_val_i = '0;
    repeat (3) tick();
    bus.core_resp_val_i  = 1'b1;
    bus.core_resp_data_i = 64'hA;
    settle();
    chk("route_rdy_a", bus.core_resp_rdy_o, 1);
    tick();
    bus.core_resp_data_i = 64'hB;
    settle();
    chk("route_rdy_b", bus.core_resp_rdy_o, 1);
    chk("route_val_a", bus.cli_resp_val_o, 4'b1000);
    chk("route_data_a", rdata(3), 64'hA);
    tick();
    bus.core_resp_data_i = 64'hC;
    settle();
    chk("route_stall", bus.core_resp_rdy_o, 0);
    chk("route_val_b", bus.cli_resp_val_o, 4'b1001);
    chk("route_data_b", rdata(0), 64'hB);
    tick();
    chk("route_val_hold", bus.cli_resp_val_o, 4'b1000);
    chk("route_still_stall", bus.core_resp_rdy_o, 0);
    bus.cli_resp_rdy_i = 4'b1111;
    settle();
    chk("route_release", bus.core_resp_rdy_o, 1);
    tick();
    bus.core_resp_val_i = 1'b0;
    bus.cli_resp_rdy_i  = '0;
    chk("route_val_c", bus.cli_resp_val_o, 4'b1000);
    chk("route_data_c", rdata(3), 64'hC);

    // ---- core backpressure
    do_reset();
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req(0, 1'b1, 64'(acc));
      settle();
      if (bus.cli_req_rdy_o[0]) acc++;
      tick();
      if (c >= 1) begin
        chk("bp_hold_val", bus.core_req_val_o, 1);
        chk("bp_hold_data", bus.core_req_data_o, 0);
      end
    end
    bus.cli_req_val_i = '0;
    chk("bp_accepted", 64'(acc), 5);
    chk("bp_rdy_low", bus.cli_req_rdy_o[0], 0);
    bus.core_req_rdy_i = 1'b1;
    order.delete();
    for (int c = 0; c < 10; c++) begin
      if (bus.core_req_val_o) order.push_back(int'(bus.core_req_data_o));
      tick();
    end
    chk("bp_drained", 64'(order.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk($sformatf("bp_item%0d", i), 64'(order[i]), 64'(i));
    end

    // ---- reset with allocs in flight
    do_reset();
    bus.core_req_rdy_i = 1'b1;
    req(1, 1'b0, 64'h7);
    tick();
    req(1, 1'b0, 64'h8);
    tick();
    bus.cli_req_val_i = '0;
    repeat (3) tick();
    chk("mid_pre_rdy", bus.core_resp_rdy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_core_val", bus.core_req_val_o, 0);
    chk("mid_resp_val", bus.cli_resp_val_o, 0);
    chk("mid_stat_alloc", bus.stat_alloc_cnt_o, 0);
    chk("mid_stat_free", bus.stat_free_cnt_o, 0);
    bus.cli_resp_rdy_i   = '1;
    bus.core_resp_val_i  = 1'b1;
    bus.core_resp_data_i = 64'h99;
    settle();
    chk("mid_resp_refused", bus.core_resp_rdy_o, 0);
    tick();
    bus.core_resp_val_i = 1'b0;
    chk("mid_no_resp", bus.cli_resp_val_o, 0);

    // ---- randomized traffic against a queue-based reference
    do_reset();
    tagq.delete();
    n_alloc = 0;
    n_free  = 0;
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      slot_full[p] = 1'b0;
      slot_d[p]    = '0;
      seqn[p]      = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic feed;
      feed = (cyc < 450);
      for (int p = 0; p < NP; p++) begin
        bus.cli_req_val_i[p]           = feed && ($urandom_range(0, 1) == 1);
        bus.cli_req_is_free_i[p]       = ($urandom_range(0, 2) == 0);
        bus.cli_req_data_i[p*DW +: DW] = {32'($urandom), 16'(seqn[p]), 8'h00, 8'(p)};
        bus.cli_resp_rdy_i[p]          = feed ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      bus.core_req_rdy_i   = feed ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.core_resp_val_i  = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.core_resp_data_i = {$urandom, $urandom};
      settle();
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rnd_resp_val%0d", p), bus.cli_resp_val_o[p], slot_full[p]);
        if (slot_full[p]) chk($sformatf("rnd_resp_data%0d", p), rdata(p), slot_d[p]);
      end
      if (bus.core_resp_val_i) begin
        chk("rnd_core_resp_rdy", bus.core_resp_rdy_o,
            !slot_full[tagq[0]] || bus.cli_resp_rdy_i[tagq[0]]);
      end
      for (int p = 0; p < NP; p++) begin
        if (slot_full[p] && bus.cli_resp_rdy_i[p]) slot_full[p] = 1'b0;
      end
      if (bus.core_resp_val_i && bus.core_resp_rdy_o && tagq.size() > 0) begin
        int h;
        h = tagq.pop_front();
        slot_full[h] = 1'b1;
        slot_d[h]    = bus.core_resp_data_i;
      end
      for (int p = 0; p < NP; p++) begin
        if (bus.cli_req_val_i[p] && bus.cli_req_rdy_o[p]) begin
          exp_q[p].push_back('{f: bus.cli_req_is_free_i[p], d: bus.cli_req_data_i[p*DW +: DW]});
          seqn[p]++;
        end
      end
      if (bus.core_req_val_o && bus.core_req_rdy_i) begin
        int   p;
        logic known;
        p     = int'(bus.core_req_data_o[7:0]);
        known = (p < NP) && (exp_q[p].size() > 0);
        chk("rnd_cmd_known", 64'(known), 1);
        if (known) begin
          req_t e;
          e = exp_q[p].pop_front();
          chk("rnd_cmd_data", bus.core_req_data_o, e.d);
          chk("rnd_cmd_type", bus.core_req_is_free_o, e.f);
          if (e.f) n_free++;
          else begin
            n_alloc++;
            tagq.push_back(p);
          end
          chk("rnd_outstanding", 64'(tagq.size() <= MO), 1);
        end
      end
      tick();
    end
    for (int p = 0; p < NP; p++) chk($sformatf("rnd_all_issued%0d", p), 64'(exp_q[p].size()), 0);
    chk("rnd_all_answered", 64'(tagq.size()), 0);
`ifdef FALAFEL_FE_STATS_EN
    chk("rnd_stat_alloc", bus.stat_alloc_cnt_o, 64'(n_alloc));
    chk("rnd_stat_free", bus.stat_free_cnt_o, 64'(n_free));
`else
    chk("rnd_stat_alloc_tied", bus.stat_alloc_cnt_o, 0);
    chk("rnd_stat_free_tied", bus.stat_free_cnt_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
